// File: rtl/my_mult_core_if.sv
// Operand/strobe/status bundle between the my_mult register file and the multiplier core.
interface my_mult_core_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      start;
    logic                      is_signed;
    logic [DATA_WIDTH-1:0]     op_a;
    logic [DATA_WIDTH-1:0]     op_b;
    logic                      busy;
    logic                      done_pulse;
    logic                      result_valid;
    logic [2*DATA_WIDTH-1:0]   product;

    // Register-file side: issues requests, reads status and product.
    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done_pulse, result_valid, product
    );

    // Core side: consumes requests, drives status and product.
    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done_pulse, result_valid, product
    );
endinterface

// File: rtl/my_mult_core.sv
// Iterative shift-add multiplier. Signed operands are converted to magnitudes on capture and
// the sign is reapplied once at the end, so one unsigned datapath serves both modes.
module my_mult_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic          ACLK,
    input  logic          ARESET,
    my_mult_core_if.slave bus
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic [PW-1:0]         product_q, product_d;

    logic [DATA_WIDTH-1:0] mag_a, mag_b;
    logic [DATA_WIDTH:0]   partial_sum;

    // Magnitude of each operand; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
    always_comb begin
        mag_a = bus.op_a;
        mag_b = bus.op_b;
        if (bus.is_signed && bus.op_a[DATA_WIDTH-1]) begin
            mag_a = -bus.op_a;
        end
        if (bus.is_signed && bus.op_b[DATA_WIDTH-1]) begin
            mag_b = -bus.op_b;
        end
    end

    // Upper-half add, one bit wider so the carry survives into the shift.
    always_comb begin
        partial_sum = {1'b0, acc_q[PW-1:DATA_WIDTH]};
        if (mplier_q[0]) begin
            partial_sum = partial_sum + {1'b0, mcand_q};
        end
    end

    // Next-state and datapath updates for the three-state sequencer.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    neg_d    = bus.is_signed & (bus.op_a[DATA_WIDTH-1] ^ bus.op_b[DATA_WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    valid_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_d    = {partial_sum, acc_q[DATA_WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                product_d = neg_q ? -acc_q : acc_q;
                done_d    = 1'b1;
                valid_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; reset discards any multiply in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            product_q <= product_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done_pulse   = done_q;
    assign bus.result_valid = valid_q;
    assign bus.product      = product_q;

endmodule

// File: tb/tb_my_mult_core.sv
// Directed bench for my_mult_core at DATA_WIDTH=32: latency, busy window, signed corners,
// start-while-busy rejection and mid-run reset.
module tb_my_mult_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    my_mult_core_if #(.DATA_WIDTH(32)) bus ();

    my_mult_core #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (6)
    ) dut (
        .ACLK  (clk),
        .ARESET(rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done_pulse), 64'd0);
        check({tag, "_valid"}, 64'(bus.result_valid), 64'd0);
        check({tag, "_product"}, bus.product, 64'd0);
    endtask

    // Issue one request and follow it for 40 edges, checking latency, busy window,
    // single done pulse and the final product.
    task automatic run_mult(input string tag, input logic sgn, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp);
        int done_at;
        int pulses;
        logic busy_ok;
        done_at = -1;
        pulses  = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_busy_k"}, 64'(bus.busy), 64'd1);
        check({tag, "_valid_k"}, 64'(bus.result_valid), 64'd0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done_pulse) begin
                pulses++;
                if (done_at < 0) done_at = c;
            end
            if (c <= 32 && !bus.busy) busy_ok = 1'b0;
            if (c >= 33 && bus.busy) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 64'(done_at), 64'd33);
        check({tag, "_pulses"}, 64'(pulses), 64'd1);
        check({tag, "_busy_window"}, 64'(busy_ok), 64'd1);
        check({tag, "_valid"}, 64'(bus.result_valid), 64'd1);
        check({tag, "_product"}, bus.product, exp);
    endtask

    initial begin
        int done_at;
        int pulses;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;

        // Power-on reset for three edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle_zero("por");

        run_mult("u_3x5", 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        run_mult("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_mult("u_zero", 1'b0, 32'h0, 32'hDEAD_BEEF, 64'h0);
        run_mult("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        run_mult("s_minxm1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_mult("s_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        // Second start during RUN, plus operand changes, must be ignored.
        done_at = -1;
        pulses  = 0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.op_a      = 32'h0101_FFFF;
        bus.op_b      = 32'hABCD_0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 10) begin
                bus.start     = 1'b1;
                bus.is_signed = 1'b1;
                bus.op_a      = 32'hDEAD_0011;
                bus.op_b      = 32'hBEEF_0011;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done_pulse) begin
                pulses++;
                if (done_at < 0) done_at = c;
            end
        end
        check("ign_latency", 64'(done_at), 64'd33);
        check("ign_pulses", 64'(pulses), 64'd1);
        check("ign_product", bus.product, 64'h00AD_2499_5534_FFFF);
        check("ign_valid", 64'(bus.result_valid), 64'd1);

        // Reset at cycle 20 of a multiply, with start poked while reset is held.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.op_a      = 32'h1234_5678;
        bus.op_b      = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_idle_zero("midrst");
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done_pulse) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'd0);
        check_idle_zero("midrst_after");

        run_mult("u_7x6", 1'b0, 32'd7, 32'd6, 64'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/my_mult_core.md
Name: my_mult_core

Overview:
- Iterative shift-add multiplier datapath behind the my_mult AXI4-Lite slave register file.
- Consumes the two operand registers and a start strobe written over S00_AXI.
- Produces a 2*DATA_WIDTH product plus status bits that the slave exposes as read-only registers.
- Fixed latency. One multiply in flight at a time.

Parameters:
- DATA_WIDTH, 32, operand width in bits. Product width is 2*DATA_WIDTH. Legal range 4..32.
- CNT_WIDTH, 6, iteration counter width. Must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- ACLK  in  1  single clock, rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request strobe from the register file (slv_reg write decode).
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned. Sampled with start.
- op_a  in  DATA_WIDTH  multiplicand. Sampled when start is accepted.
- op_b  in  DATA_WIDTH  multiplier. Sampled when start is accepted.
- busy  out  1  high while a multiply is in progress.
- done_pulse  out  1  one-cycle strobe when the product is written.
- result_valid  out  1  level flag. Product register holds a completed result.
- product  out  2*DATA_WIDTH  result. Maps low word to slv_reg2 and high word to slv_reg3.

Behaviour:
- Reset (ARESET high at a rising edge):
  - state=IDLE
  - busy=0, done_pulse=0, result_valid=0, product=0
  - counter=0, internal accumulator and operand registers cleared.
  - Reset has priority over everything, including mid-operation. An in-flight multiply is discarded and no done_pulse is produced.
- States: IDLE, RUN, FINISH.
- IDLE:
  - If start=1 at edge k, capture op_a, op_b and is_signed.
  - Signed mode: store |op_a| and |op_b|, and record neg = sign(op_a) XOR sign(op_b).
  - Unsigned mode: neg=0.
  - Clear the accumulator, counter=0, result_valid=0, busy=1, go to RUN.
  - product keeps its old value until FINISH completes.
- RUN:
  - Each edge: if multiplier LSB=1, add the multiplicand to the upper half of the accumulator. The add is DATA_WIDTH+1 bits wide so the carry is kept.
  - Then shift {carry, acc} right by 1 and increment the counter.
  - After DATA_WIDTH iterations (counter==DATA_WIDTH-1 on the last one), go to FINISH.
  - There is no early termination. Zero operands still take the full latency.
- FINISH (one edge):
  - product = neg ? two's-complement negate(acc) : acc.
  - done_pulse=1 for exactly this one following cycle.
  - result_valid=1, busy=0, go to IDLE.
- Latency: start sampled at edge k gives product, done_pulse and result_valid visible after edge k+DATA_WIDTH+1. For DATA_WIDTH=32 that is 33 clocks.
- busy is high from after edge k through edge k+DATA_WIDTH+1.
- start while busy=1 (RUN or FINISH) is ignored. It is not queued and has no side effects. Software polls busy/result_valid.
- start in the same cycle as done_pulse (state IDLE) is accepted normally. result_valid drops on the next edge.
- is_signed, op_a and op_b changing during RUN have no effect. Only the captured copies are used.
- Signed corner case: -2^(W-1) has magnitude 2^(W-1), which fits in W unsigned bits. The result is exact for every input pair, including (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).
- result_valid stays high until the next accepted start or reset. product is stable while result_valid=1.
- done_pulse never stays asserted for more than one cycle.

Test Plan:
- Reset with ARESET high for 3 cycles, outputs poked mid-run -> all outputs 0 and state IDLE on the first edge after ARESET drops.
- Unsigned op_a=3, op_b=5, start at edge k -> busy high for edges k+1..k+33. Exactly one done_pulse. product=0x000000000000000F, result_valid=1.
- Unsigned op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> product=0xFFFFFFFE00000001. Also op_a=0, op_b=0xDEADBEEF -> product=0 after the full 33-cycle latency.
- Signed cases:
  - op_a=0xFFFFFFFD (-3), op_b=5 -> product=0xFFFFFFFFFFFFFFF1.
  - op_a=0x80000000, op_b=0xFFFFFFFF -> product=0x0000000080000000.
  - op_a=op_b=0x80000000 -> product=0x4000000000000000.
- Start 0x0101FFFF * 0xABCD0001, then pulse start with 0xDEAD0011 / 0xBEEF0011 at cycle 10 -> second request ignored. Product equals the first pair's product and there is a single done_pulse.
- Assert ARESET at cycle 20 of a multiply -> no done_pulse, result_valid=0, product=0. A new start 7*6 afterwards -> product=42 after 33 cycles.
